// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM encoding,
// BCD digit limits and the default centisecond prescaler divide.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CLEARED = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // 100 MHz clock / 1_000_000 = 100 Hz centisecond tick
  localparam int DEFAULT_TICK_DIVIDE = 1_000_000;

  // Digit order, least significant first: cs_ones, cs_tens, sec_ones, sec_tens
  localparam int NUM_DIGITS = 4;

  // Highest legal value of a digit position; only the seconds-tens digit stops at 5
  function automatic logic [3:0] digit_limit(input int idx);
    return (idx == NUM_DIGITS - 1) ? SEC_TENS_MAX : DIGIT_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_control_if.sv
// Button/display bundle between the debouncers, the stopwatch control
// stage and the display multiplexer.
interface stopwatch_control_if;
  logic        StartStop;
  logic        Clear;
  logic        Running;
  logic        Tick;
  logic [15:0] Digits;

  // Driver side: supplies button levels, observes time and status
  modport master (
    output StartStop,
    output Clear,
    input  Running,
    input  Tick,
    input  Digits
  );

  // Stopwatch control side
  modport slave (
    input  StartStop,
    input  Clear,
    output Running,
    output Tick,
    output Digits
  );
endinterface

// File: rtl/bcd_time_counter.sv
// Four-digit BCD time counter SS.CC (00.00 - 59.99) advanced by the
// centisecond tick; Clear has priority over Tick and zeroes every digit.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        Clear,
  input  logic        Tick,
  output logic [15:0] Digits
);

  // carry[gi] = increment request into digit gi
  logic [NUM_DIGITS-1:0] carry;

  assign carry[0] = Tick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [3:0] LIMIT = digit_limit(gi);

      logic [3:0] digit_q;
      logic       at_limit;

      // ">=" rather than "==" so an out-of-range value wraps instead of sticking
      assign at_limit = (digit_q >= LIMIT);

      if (gi < NUM_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & at_limit;
      end

      // Digit register: clear, or step and wrap at this position's limit
      always_ff @(posedge CLOCK) begin
        if (Reset || Clear) begin
          digit_q <= 4'd0;
        end else if (carry[gi]) begin
          digit_q <= at_limit ? 4'd0 : digit_q + 4'd1;
        end
      end

      assign Digits[4*gi +: 4] = digit_q;
    end
  endgenerate

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control stage: button press detection, CLEARED/RUNNING/STOPPED
// FSM, centisecond prescaler and the BCD time counter it drives.
module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIVIDE = DEFAULT_TICK_DIVIDE
) (
  input  logic               CLOCK,
  input  logic               Reset,
  stopwatch_control_if.slave bus
);

  localparam int                  PRESC_W    = $clog2(TICK_DIVIDE);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIVIDE - 1);

  logic               ss_prev_q;
  logic               clr_prev_q;
  logic               ss_press;
  logic               clr_press;
  state_t             state_q;
  state_t             state_d;
  logic               running_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic               tick;
  logic               clear_digits;

  // Previous button levels; reset high so a button held through reset is not a press
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
    end else begin
      ss_prev_q  <= bus.StartStop;
      clr_prev_q <= bus.Clear;
    end
  end

  assign ss_press  = bus.StartStop & ~ss_prev_q;
  assign clr_press = bus.Clear     & ~clr_prev_q;

  // Next-state decode; in STOPPED a Clear press beats a simultaneous Start/Stop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEARED: if (ss_press) state_d = RUNNING;
      RUNNING: if (ss_press) state_d = STOPPED;
      STOPPED: begin
        if (clr_press)     state_d = CLEARED;
        else if (ss_press) state_d = RUNNING;
      end
      default: state_d = CLEARED;
    endcase
  end

  // FSM state register with registered Running output
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q   <= CLEARED;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUNNING);
    end
  end

  // Tick depends only on registered state, so it is glitch-free for one full cycle
  assign tick = (state_q == RUNNING) && (presc_q == PRESC_LAST);

  // Prescaler: counts while RUNNING (including the stop edge), holds when
  // STOPPED, zero whenever CLEARED is current or being entered
  always_comb begin
    presc_d = presc_q;
    if (state_d == CLEARED) begin
      presc_d = '0;
    end else if (state_q == RUNNING) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Digits zero on the same edge the FSM enters CLEARED
  assign clear_digits = (state_d == CLEARED);

  bcd_time_counter u_time_counter (
    .CLOCK  (CLOCK),
    .Reset  (Reset),
    .Clear  (clear_digits),
    .Tick   (tick),
    .Digits (bus.Digits)
  );

  assign bus.Running = running_q;
  assign bus.Tick    = tick;

endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench for stopwatch_control with TICK_DIVIDE = 4. Stimulus
// pushes expected Digits for every Tick and expected state snapshots;
// a negedge monitor pops and compares them.
module tb_stopwatch_control;

  logic clk = 1'b0;
  logic srst;

  stopwatch_control_if bus ();

  stopwatch_control #(.TICK_DIVIDE(4)) dut (
    .CLOCK (clk),
    .Reset (srst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        run;
    logic [15:0] dig;
    bit          chk_tick;
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] tick_q[$];

  int          vectors     = 0;
  int          miscompares = 0;
  bit          pend        = 1'b0;
  logic [15:0] pend_val    = 16'h0;
  bit          prev_tick   = 1'b0;

  // Centiseconds -> BCD SS.CC, wrapping at one minute
  function automatic logic [15:0] to_bcd(input int cs);
    int c, sec;
    c   = cs % 6000;
    sec = c / 100;
    c   = c % 100;
    return {4'(sec / 10), 4'(sec % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Level high for exactly one sampling edge, then low
  task automatic press(input logic s, input logic c);
    bus.StartStop = s;
    bus.Clear     = c;
    @(posedge clk);
    #1;
    bus.StartStop = 1'b0;
    bus.Clear     = 1'b0;
  endtask

  task automatic expect_state(input string name, input logic run,
                              input logic [15:0] dig, input bit chk_tick);
    snap_t s;
    s.name     = name;
    s.run      = run;
    s.dig      = dig;
    s.chk_tick = chk_tick;
    snap_q.push_back(s);
  endtask

  task automatic push_ticks(input int first, input int last);
    for (int k = first; k <= last; k++) tick_q.push_back(to_bcd(k));
  endtask

  // Monitor: tick results, tick spacing and state snapshots
  always @(negedge clk) begin
    if (pend) begin
      vectors++;
      if (bus.Digits !== pend_val) begin
        miscompares++;
        $display("FAIL tick_digits: got %h expected %h", bus.Digits, pend_val);
      end
      pend = 1'b0;
    end
    if (bus.Tick === 1'b1) begin
      vectors++;
      if (prev_tick) begin
        miscompares++;
        $display("FAIL tick_consecutive: got tick high 2 cycles expected 1");
      end
      vectors++;
      if (tick_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tick: got Tick=1 expected Tick=0 at %0t", $time);
      end else begin
        pend_val = tick_q.pop_front();
        pend     = 1'b1;
      end
    end
    prev_tick = (bus.Tick === 1'b1);
    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      vectors++;
      if ({bus.Running, bus.Digits} !== {s.run, s.dig}) begin
        miscompares++;
        $display("FAIL %s: got Running=%b Digits=%h expected Running=%b Digits=%h",
                 s.name, bus.Running, bus.Digits, s.run, s.dig);
      end
      if (s.chk_tick) begin
        vectors++;
        if (bus.Tick !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_tick: got Tick=%b expected 0", s.name, bus.Tick);
        end
      end
    end
  end

  initial begin
    srst          = 1'b1;
    bus.StartStop = 1'b1;
    bus.Clear     = 1'b0;

    // Reset with Start/Stop held: no press until released and pressed again
    cyc(1);
    expect_state("reset_values", 1'b0, 16'h0000, 1'b1);
    cyc(2);
    srst = 1'b0;
    cyc(4);
    expect_state("held_through_reset", 1'b0, 16'h0000, 1'b0);
    bus.StartStop = 1'b0;
    cyc(2);
    expect_state("release_no_press", 1'b0, 16'h0000, 1'b0);

    // Start, stop after 6 cycles (prescaler 2, 00.01), hold, resume
    push_ticks(1, 1);
    press(1'b1, 1'b0);                            // E
    expect_state("start_press", 1'b1, 16'h0000, 1'b0);
    cyc(5);
    press(1'b1, 1'b0);                            // E+6
    expect_state("stop_after_6", 1'b0, 16'h0001, 1'b0);
    cyc(20);
    expect_state("held_while_stopped", 1'b0, 16'h0001, 1'b0);
    push_ticks(2, 2);
    press(1'b1, 1'b0);                            // R
    expect_state("restart", 1'b1, 16'h0001, 1'b0);
    cyc(1);
    expect_state("restart_plus1", 1'b1, 16'h0001, 1'b0);
    cyc(1);
    expect_state("resume_tick_2cyc", 1'b1, 16'h0002, 1'b0);

    // Clear ignored while running; run to 01.23, stop, clear
    push_ticks(3, 123);
    press(1'b0, 1'b1);                            // R+3
    expect_state("clear_ignored_running", 1'b1, 16'h0002, 1'b0);
    cyc(483);
    expect_state("reach_0123", 1'b1, 16'h0123, 1'b0);
    press(1'b1, 1'b0);
    expect_state("stopped_0123", 1'b0, 16'h0123, 1'b0);
    press(1'b0, 1'b1);
    expect_state("clear_while_stopped", 1'b0, 16'h0000, 1'b0);

    // Prescaler was zeroed: first tick exactly 4 edges after start
    push_ticks(1, 1);
    press(1'b1, 1'b0);                            // S
    expect_state("start_after_clear", 1'b1, 16'h0000, 1'b0);
    cyc(3);
    expect_state("no_early_tick", 1'b1, 16'h0000, 1'b0);
    cyc(1);
    expect_state("first_tick_after_clear", 1'b1, 16'h0001, 1'b0);

    // Simultaneous presses in each state
    press(1'b1, 1'b1);                            // S+5
    expect_state("simul_running_to_stopped", 1'b0, 16'h0001, 1'b0);
    cyc(1);
    press(1'b1, 1'b1);                            // S+7
    expect_state("simul_stopped_to_cleared", 1'b0, 16'h0000, 1'b0);
    cyc(1);
    press(1'b1, 1'b1);                            // S+9
    expect_state("simul_cleared_to_running", 1'b1, 16'h0000, 1'b0);

    // Stop on the tick edge: increment lands, prescaler holds at 0
    push_ticks(1, 1);
    cyc(3);
    press(1'b1, 1'b0);                            // S+13
    expect_state("stop_on_tick", 1'b0, 16'h0001, 1'b0);
    cyc(1);
    push_ticks(2, 2);
    press(1'b1, 1'b0);                            // T
    expect_state("restart_after_tick_stop", 1'b1, 16'h0001, 1'b0);
    cyc(3);
    expect_state("full_period_pending", 1'b1, 16'h0001, 1'b0);
    cyc(1);
    expect_state("full_period_tick", 1'b1, 16'h0002, 1'b0);

    // Reset mid-run, one edge before a tick would fire, buttons held
    cyc(2);
    srst          = 1'b1;
    bus.StartStop = 1'b1;
    bus.Clear     = 1'b1;
    cyc(1);
    expect_state("reset_mid_run", 1'b0, 16'h0000, 1'b1);
    cyc(2);
    srst = 1'b0;
    cyc(3);
    expect_state("buttons_held_after_reset", 1'b0, 16'h0000, 1'b0);
    bus.StartStop = 1'b0;
    bus.Clear     = 1'b0;
    cyc(2);
    expect_state("buttons_released", 1'b0, 16'h0000, 1'b0);

    // Long run: 00.10, 09.99 -> 10.00, 59.99 -> 00.00
    push_ticks(1, 6000);
    press(1'b1, 1'b0);                            // L
    expect_state("long_start", 1'b1, 16'h0000, 1'b0);
    cyc(40);
    expect_state("run_40_cycles", 1'b1, 16'h0010, 1'b0);
    cyc(3956);
    expect_state("reach_0999", 1'b1, 16'h0999, 1'b0);
    cyc(4);
    expect_state("carry_to_1000", 1'b1, 16'h1000, 1'b0);
    cyc(19996);
    expect_state("reach_5999", 1'b1, 16'h5999, 1'b0);
    cyc(4);
    expect_state("wrap_5999", 1'b1, 16'h0000, 1'b0);
    press(1'b1, 1'b0);
    expect_state("final_stop", 1'b0, 16'h0000, 1'b0);
    cyc(3);

    vectors++;
    if (tick_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL missing_ticks: got %0d ticks outstanding expected 0", tick_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
